ysyx_22040895_idu_pipe: RTL and testbench
=========================================

Name: ysyx_22040895_idu_pipe

Overview:
Registered, parametrised decode stage that replaces the combinational field-splitter. It sits between IFU and EXU in the pipelined core and accepts {pc, inst} over a valid/ready handshake. It fully decodes RV64I formats, producing a sign-extended XLEN immediate, format one-hot, register-enable flags and an illegal flag. A 2-entry skid buffer gives full throughput under back-pressure, and a flush input squashes in-flight instructions on redirect.

Parameters:
XLEN, 64, datapath and PC width; immediates sign-extended to this.
ILEN, 32, instruction width (fixed encoding positions assume 32).
REG_AW, 5, register address width.

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  synchronous reset, active-low
flush_i  in  1  squash all buffered entries and drop this cycle's input
in_valid_i  in  1  IFU offers {pc, inst}
in_ready_o  out  1  stage can accept
pc_i  in  XLEN  instruction PC
inst_i  in  ILEN  raw instruction
out_valid_o  out  1  decoded entry available
out_ready_i  in  1  EXU accepts
pc_o  out  XLEN  PC of entry
inst_o  out  ILEN  raw instruction passthrough
opcode_o  out  7  inst[6:0]
func3_o  out  3  inst[14:12]
func7_o  out  7  inst[31:25]
rs1addr_o  out  REG_AW  inst[19:15], 0 when unused
rs2addr_o  out  REG_AW  inst[24:20], 0 when unused
rdaddr_o  out  REG_AW  inst[11:7], 0 when unused
rs1_en_o / rs2_en_o / rd_we_o  out  1 each  operand-read / writeback enables
imm_o  out  XLEN  sign-extended immediate
fmt_o  out  6  one-hot {J,U,B,S,I,R} (bit0=R)
illegal_o  out  1  opcode not recognised

Behaviour:
- Reset (rst=0 at posedge): both buffer entries invalid. out_valid_o=0, in_ready_o=1, all data outputs 0. Reset dominates flush and handshakes.
- Decode is combinational on inst_i; the decoded bundle is stored, never re-decoded from stored inst.
- Opcode map:
  - R: OP 0110011, OP-32 0111011.
  - I: LOAD 0000011, OP-IMM 0010011, OP-IMM-32 0011011, JALR 1100111, MISC-MEM 0001111, SYSTEM 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: LUI 0110111, AUIPC 0010111.
  - J: JAL 1101111.
  - Anything else: fmt=0, imm=0, all enables 0, illegal=1. The entry still flows downstream.
- Immediates, sign bit inst[31]:
  - I: inst[31:20].
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U: {inst[31:12],12'h0}, sign-extended from bit 31.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - R: 0.
- Enables and register addresses:
  - rs1_en for R/I/S/B.
  - rs2_en for R/S/B.
  - rd_we for R/I/U/J with rd!=0.
  - A register address field is forced to 0 when its enable is 0.
- Buffer: main entry M drives the outputs; skid entry K.
  - in_ready_o = !K.valid (registered-state derived, no comb path from out_ready_i).
  - Accept = in_valid_i & in_ready_o & !flush_i.
  - Output fire = out_valid_o & out_ready_i.
  - Latency: accepted at edge N appears with out_valid_o=1 after edge N when M is empty or firing.
  - Accept while M valid and not firing: entry goes to K, and in_ready_o=0 next cycle.
  - Fire with K valid: K moves to M and K clears. A simultaneous accept is impossible since in_ready=0.
  - Fire with M valid, K empty, accept: new entry replaces M (back-to-back, 1/cycle).
  - Order is strictly FIFO; no entry is dropped or duplicated except by flush.
- flush_i=1 at edge: M and K invalidated, input not accepted, out_valid_o=0 next cycle, in_ready_o=1 next cycle. An output fire in the flush cycle is still seen by the EXU (handshake completes).
- out_valid_o must not drop and data must stay stable while out_ready_i=0 (except flush/reset).

Test Plan:
- beq x1,x2,-4 (inst 0xFE208EE3, pc 0x80000010), out_ready=1 -> next cycle out_valid=1, fmt=B(6'b001000), imm=0xFFFFFFFFFFFFFFFC, rs1=1, rs2=2, rd=0, rd_we=0.
- Back-to-back jal x1,+2048 (0x001000EF), lui x5,0x80000 (0x800002B7), sd x2,-8(x3) (0xFE21BC23) -> outputs in order with imm 0x800, 0xFFFFFFFF80000000, 0xFFFFFFFFFFFFFFF8; fmt J,U,S; one per cycle.
- Back-pressure: out_ready=0 for 3 cycles while sending 3 instructions -> two are held (M,K), in_ready=0 after the 2nd accept, and the 3rd waits. Release -> all 3 emerge in order, none lost.
- Flush with M and K full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the squashed PCs never appear.
- inst 0x00000000 -> illegal=1, fmt=0, imm=0, enables 0; add x0,x1,x2 -> rd_we=0, rdaddr=0.
- Reset asserted mid-stall with both entries full -> next cycle out_valid=0, all outputs 0, in_ready=1. Reset held during in_valid=1 -> nothing accepted.

Source files
------------

// File: rtl/ysyx_22040895_idu_pipe.sv
// RV64I decode stage: combinational decode of the incoming instruction, stored into a
// two-entry (main + skid) buffer so IFU/EXU see a full-throughput valid/ready interface.
module ysyx_22040895_idu_pipe #(
    parameter int XLEN   = 64,
    parameter int ILEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [ILEN-1:0]   inst_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   pc_o,
    output logic [ILEN-1:0]   inst_o,
    output logic [6:0]        opcode_o,
    output logic [2:0]        func3_o,
    output logic [6:0]        func7_o,
    output logic [REG_AW-1:0] rs1addr_o,
    output logic [REG_AW-1:0] rs2addr_o,
    output logic [REG_AW-1:0] rdaddr_o,
    output logic              rs1_en_o,
    output logic              rs2_en_o,
    output logic              rd_we_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [5:0]        fmt_o,
    output logic              illegal_o
);

    localparam int F_R = 0;
    localparam int F_I = 1;
    localparam int F_S = 2;
    localparam int F_B = 3;
    localparam int F_U = 4;
    localparam int F_J = 5;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [ILEN-1:0]   inst;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              rs1_en;
        logic              rs2_en;
        logic              rd_we;
        logic [XLEN-1:0]   imm;
        logic [5:0]        fmt;
        logic              illegal;
    } dec_t;

    dec_t dec;
    dec_t m_ent;
    dec_t k_ent;
    logic m_vld;
    logic k_vld;

    logic [6:0]        op;
    logic [REG_AW-1:0] rd_f;
    logic              sgn;
    logic [5:0]        fmt;
    logic              ill;
    logic [XLEN-1:0]   imm;
    logic              rs1_en;
    logic              rs2_en;
    logic              rd_we;

    assign op   = inst_i[6:0];
    assign rd_f = inst_i[11:7];
    assign sgn  = inst_i[31];

    always_comb begin
        fmt = '0;
        ill = 1'b0;
        case (op)
            7'b0110011, 7'b0111011: fmt[F_R] = 1'b1;
            7'b0000011, 7'b0010011, 7'b0011011,
            7'b1100111, 7'b0001111, 7'b1110011: fmt[F_I] = 1'b1;
            7'b0100011: fmt[F_S] = 1'b1;
            7'b1100011: fmt[F_B] = 1'b1;
            7'b0110111, 7'b0010111: fmt[F_U] = 1'b1;
            7'b1101111: fmt[F_J] = 1'b1;
            default: ill = 1'b1;
        endcase
    end

    always_comb begin
        imm = '0;
        if (fmt[F_I])
            imm = {{(XLEN-12){sgn}}, inst_i[31:20]};
        else if (fmt[F_S])
            imm = {{(XLEN-12){sgn}}, inst_i[31:25], inst_i[11:7]};
        else if (fmt[F_B])
            imm = {{(XLEN-13){sgn}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        else if (fmt[F_U])
            imm = {{(XLEN-32){sgn}}, inst_i[31:12], 12'h000};
        else if (fmt[F_J])
            imm = {{(XLEN-21){sgn}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    end

    assign rs1_en = fmt[F_R] | fmt[F_I] | fmt[F_S] | fmt[F_B];
    assign rs2_en = fmt[F_R] | fmt[F_S] | fmt[F_B];
    // Writes to x0 are dropped here so EXU never needs its own rd!=0 check.
    assign rd_we  = (fmt[F_R] | fmt[F_I] | fmt[F_U] | fmt[F_J]) & (rd_f != '0);

    always_comb begin
        dec         = '0;
        dec.pc      = pc_i;
        dec.inst    = inst_i;
        dec.rs1     = rs1_en ? inst_i[19:15] : '0;
        dec.rs2     = rs2_en ? inst_i[24:20] : '0;
        dec.rd      = rd_we  ? rd_f          : '0;
        dec.rs1_en  = rs1_en;
        dec.rs2_en  = rs2_en;
        dec.rd_we   = rd_we;
        dec.imm     = imm;
        dec.fmt     = fmt;
        dec.illegal = ill;
    end

    logic accept;
    logic fire;

    // Ready depends only on skid occupancy, so there is no comb path from out_ready_i.
    assign in_ready_o = !k_vld;
    assign accept     = in_valid_i & in_ready_o & !flush_i;
    assign fire       = m_vld & out_ready_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            m_vld <= 1'b0;
            k_vld <= 1'b0;
            m_ent <= '0;
            k_ent <= '0;
        end else if (flush_i) begin
            m_vld <= 1'b0;
            k_vld <= 1'b0;
        end else if (k_vld) begin
            if (fire) begin
                m_ent <= k_ent;
                k_vld <= 1'b0;
            end
        end else if (accept) begin
            if (!m_vld || fire) begin
                m_ent <= dec;
                m_vld <= 1'b1;
            end else begin
                k_ent <= dec;
                k_vld <= 1'b1;
            end
        end else if (fire) begin
            m_vld <= 1'b0;
        end
    end

    assign out_valid_o = m_vld;
    assign pc_o        = m_ent.pc;
    assign inst_o      = m_ent.inst;
    assign opcode_o    = m_ent.inst[6:0];
    assign func3_o     = m_ent.inst[14:12];
    assign func7_o     = m_ent.inst[31:25];
    assign rs1addr_o   = m_ent.rs1;
    assign rs2addr_o   = m_ent.rs2;
    assign rdaddr_o    = m_ent.rd;
    assign rs1_en_o    = m_ent.rs1_en;
    assign rs2_en_o    = m_ent.rs2_en;
    assign rd_we_o     = m_ent.rd_we;
    assign imm_o       = m_ent.imm;
    assign fmt_o       = m_ent.fmt;
    assign illegal_o   = m_ent.illegal;

endmodule

// File: tb/tb_ysyx_22040895_idu_pipe.sv
// Directed bench for the decode stage: decode values, back-to-back flow, back-pressure, flush, reset.
module tb_ysyx_22040895_idu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] pc_i;
    logic [31:0] inst_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] pc_o;
    logic [31:0] inst_o;
    logic [6:0]  opcode_o;
    logic [2:0]  func3_o;
    logic [6:0]  func7_o;
    logic [4:0]  rs1addr_o;
    logic [4:0]  rs2addr_o;
    logic [4:0]  rdaddr_o;
    logic        rs1_en_o;
    logic        rs2_en_o;
    logic        rd_we_o;
    logic [63:0] imm_o;
    logic [5:0]  fmt_o;
    logic        illegal_o;

    int n_chk = 0;
    int n_bad = 0;

    localparam logic [31:0] BEQ  = 32'hFE208EE3;
    localparam logic [31:0] JAL  = 32'h001000EF;
    localparam logic [31:0] LUI  = 32'h800002B7;
    localparam logic [31:0] SD   = 32'hFE21BC23;
    localparam logic [31:0] ADD0 = 32'h00208033;

    ysyx_22040895_idu_pipe dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .inst_i(inst_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .pc_o(pc_o), .inst_o(inst_o), .opcode_o(opcode_o),
        .func3_o(func3_o), .func7_o(func7_o),
        .rs1addr_o(rs1addr_o), .rs2addr_o(rs2addr_o), .rdaddr_o(rdaddr_o),
        .rs1_en_o(rs1_en_o), .rs2_en_o(rs2_en_o), .rd_we_o(rd_we_o),
        .imm_o(imm_o), .fmt_o(fmt_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] pc, input logic [31:0] inst);
        in_valid_i = 1'b1;
        pc_i       = pc;
        inst_i     = inst;
    endtask

    initial begin
        rst = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        pc_i = '0; inst_i = '0;

        // reset state, and nothing accepted while reset is held
        tick();
        chk("rst_vld", out_valid_o, 0);
        chk("rst_rdy", in_ready_o, 1);
        chk("rst_pc", pc_o, 0);
        chk("rst_imm", imm_o, 0);
        chk("rst_inst", inst_o, 0);
        drive(64'h1234, JAL);
        tick();
        chk("rst_hold_vld", out_valid_o, 0);
        rst = 1'b1; in_valid_i = 1'b0;
        tick();
        chk("rst_rel_vld", out_valid_o, 0);

        // beq x1,x2,-4
        drive(64'h80000010, BEQ);
        tick();
        in_valid_i = 1'b0;
        chk("beq_vld", out_valid_o, 1);
        chk("beq_pc", pc_o, 64'h80000010);
        chk("beq_fmt", fmt_o, 6'b001000);
        chk("beq_imm", imm_o, 64'hFFFFFFFFFFFFFFFC);
        chk("beq_rs1", rs1addr_o, 1);
        chk("beq_rs2", rs2addr_o, 2);
        chk("beq_rd", rdaddr_o, 0);
        chk("beq_rdwe", rd_we_o, 0);
        chk("beq_en", {rs1_en_o, rs2_en_o}, 2'b11);
        chk("beq_op", opcode_o, 7'b1100011);
        chk("beq_f7", func7_o, 7'h7F);
        tick();
        chk("beq_drain", out_valid_o, 0);

        // back-to-back jal / lui / sd, one per cycle
        drive(64'h100, JAL);
        tick();
        chk("jal_pc", pc_o, 64'h100);
        chk("jal_imm", imm_o, 64'h800);
        chk("jal_fmt", fmt_o, 6'b100000);
        chk("jal_rd", {rd_we_o, rdaddr_o}, {1'b1, 5'd1});
        chk("jal_rs1", {rs1_en_o, rs1addr_o}, 0);
        drive(64'h104, LUI);
        tick();
        chk("lui_pc", pc_o, 64'h104);
        chk("lui_imm", imm_o, 64'hFFFFFFFF80000000);
        chk("lui_fmt", fmt_o, 6'b010000);
        chk("lui_rd", rdaddr_o, 5);
        drive(64'h108, SD);
        tick();
        in_valid_i = 1'b0;
        chk("sd_pc", pc_o, 64'h108);
        chk("sd_imm", imm_o, 64'hFFFFFFFFFFFFFFF8);
        chk("sd_fmt", fmt_o, 6'b000100);
        chk("sd_regs", {rs1addr_o, rs2addr_o, rdaddr_o, rd_we_o}, {5'd3, 5'd2, 5'd0, 1'b0});
        chk("sd_f3", func3_o, 3);
        tick();
        chk("b2b_drain", out_valid_o, 0);

        // back-pressure: two held, third waits, then all emerge in order
        out_ready_i = 1'b0;
        drive(64'h200, JAL);
        tick();
        chk("bp_rdy1", in_ready_o, 1);
        chk("bp_pc1", pc_o, 64'h200);
        drive(64'h204, LUI);
        tick();
        chk("bp_rdy2", in_ready_o, 0);
        chk("bp_hold1", pc_o, 64'h200);
        drive(64'h208, SD);
        tick();
        chk("bp_rdy3", in_ready_o, 0);
        chk("bp_hold2", {out_valid_o, pc_o}, {1'b1, 64'h200});
        chk("bp_hold_imm", imm_o, 64'h800);
        out_ready_i = 1'b1;
        tick();
        chk("bp_out2", pc_o, 64'h204);
        chk("bp_out2_imm", imm_o, 64'hFFFFFFFF80000000);
        chk("bp_rdy4", in_ready_o, 1);
        tick();
        in_valid_i = 1'b0;
        chk("bp_out3", {out_valid_o, pc_o}, {1'b1, 64'h208});
        tick();
        chk("bp_drain", out_valid_o, 0);

        // flush with both entries full and input offered
        out_ready_i = 1'b0;
        drive(64'h300, JAL);
        tick();
        drive(64'h304, LUI);
        tick();
        chk("fl_full", in_ready_o, 0);
        drive(64'h308, SD);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0; in_valid_i = 1'b0;
        chk("fl_vld", out_valid_o, 0);
        chk("fl_rdy", in_ready_o, 1);
        out_ready_i = 1'b1;
        tick();
        chk("fl_none", out_valid_o, 0);

        // illegal opcode and add to x0
        drive(64'h400, 32'h0);
        tick();
        chk("ill_vld", out_valid_o, 1);
        chk("ill_flag", illegal_o, 1);
        chk("ill_fmt", fmt_o, 0);
        chk("ill_imm", imm_o, 0);
        chk("ill_en", {rs1_en_o, rs2_en_o, rd_we_o}, 0);
        drive(64'h404, ADD0);
        tick();
        in_valid_i = 1'b0;
        chk("add_pc", pc_o, 64'h404);
        chk("add_rd", {rd_we_o, rdaddr_o}, 0);
        chk("add_rs", {rs1addr_o, rs2addr_o}, {5'd1, 5'd2});
        chk("add_fmt", {illegal_o, fmt_o}, 7'b0000001);
        tick();

        // reset mid-stall with both entries full
        out_ready_i = 1'b0;
        drive(64'h500, JAL);
        tick();
        drive(64'h504, LUI);
        tick();
        chk("rs_full", in_ready_o, 0);
        rst = 1'b0;
        tick();
        chk("rs_vld", out_valid_o, 0);
        chk("rs_rdy", in_ready_o, 1);
        chk("rs_pc", pc_o, 0);
        chk("rs_imm", imm_o, 0);
        chk("rs_misc", {fmt_o, rdaddr_o, rd_we_o, inst_o}, 0);
        tick();
        chk("rs_hold", out_valid_o, 0);
        rst = 1'b1; in_valid_i = 1'b0;
        tick();
        chk("rs_after", out_valid_o, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
